// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding and hazard unit.
// State encoding, default widths and the zero-register constant.
package fwd_pkg;
    typedef logic [0:0] state_t;

    localparam state_t RUN   = 1'b0;
    localparam state_t STALL = 1'b1;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int ZERO_REG       = 0;
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Operand-read bus between decode and the forwarding unit.
// The decode side drives requests, the unit returns operands and status.
interface fwd_hazard_unit_if
    import fwd_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_SRC    = 2,
    parameter int NUM_FWD    = 3,
    parameter int CNT_W      = 16
);
    logic                          id_valid;
    logic                          fwd_en;
    logic                          clr_cnt;
    logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]            src_used;
    logic [NUM_SRC*DATA_W-1:0]     rf_data;
    logic [NUM_FWD-1:0]            st_wb_en;
    logic [NUM_FWD*REG_ADDR_W-1:0] st_dest;
    logic [NUM_FWD*DATA_W-1:0]     st_data;
    logic [NUM_FWD-1:0]            st_data_vld;
    logic [NUM_SRC*DATA_W-1:0]     opnd;
    logic [NUM_SRC-1:0]            fwd_hit;
    logic                          stall;
    logic                          stall_start;
    logic [CNT_W-1:0]              stall_cycles;
    logic [CNT_W-1:0]              fwd_events;
    logic                          wd_err;

    modport master (
        output id_valid, fwd_en, clr_cnt, src_addr, src_used, rf_data,
        output st_wb_en, st_dest, st_data, st_data_vld,
        input  opnd, fwd_hit, stall, stall_start,
        input  stall_cycles, fwd_events, wd_err
    );

    modport slave (
        input  id_valid, fwd_en, clr_cnt, src_addr, src_used, rf_data,
        input  st_wb_en, st_dest, st_data, st_data_vld,
        output opnd, fwd_hit, stall, stall_start,
        output stall_cycles, fwd_events, wd_err
    );
endinterface

// File: rtl/fwd_src_sel.sv
// Per-source priority matcher: youngest matching stage wins.
// Produces the resolved operand, a forward hit and a hazard flag.
module fwd_src_sel
    import fwd_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_FWD    = 3
) (
    input  logic                          fwd_en_i,
    input  logic                          used_i,
    input  logic [REG_ADDR_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]             rf_data_i,
    input  logic [NUM_FWD-1:0]            st_wb_en_i,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] st_dest_i,
    input  logic [NUM_FWD*DATA_W-1:0]     st_data_i,
    input  logic [NUM_FWD-1:0]            st_data_vld_i,
    output logic [DATA_W-1:0]             opnd_o,
    output logic                          hit_o,
    output logic                          hazard_o
);
    logic              found;
    logic              win_vld;
    logic [DATA_W-1:0] win_data;

    // Scan oldest to youngest so the youngest match is the last one kept
    always_comb begin
        found    = 1'b0;
        win_vld  = 1'b0;
        win_data = '0;
        for (int s = NUM_FWD - 1; s >= 0; s--) begin
            if (used_i && (addr_i != REG_ADDR_W'(ZERO_REG)) && st_wb_en_i[s] &&
                (st_dest_i[s*REG_ADDR_W +: REG_ADDR_W] == addr_i)) begin
                found    = 1'b1;
                win_vld  = st_data_vld_i[s];
                win_data = st_data_i[s*DATA_W +: DATA_W];
            end
        end
    end

    // Forward a ready winner; an unready winner or disabled forwarding is a hazard
    always_comb begin
        opnd_o   = rf_data_i;
        hit_o    = 1'b0;
        hazard_o = 1'b0;
        if (found) begin
            if (fwd_en_i && win_vld) begin
                opnd_o = win_data;
                hit_o  = 1'b1;
            end else begin
                hazard_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit at decode/operand-read.
// Stall FSM with watchdog plus saturating stall/forward counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int NUM_SRC    = 2,
    parameter int NUM_FWD    = 3,
    parameter int MAX_STALL  = 16,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fwd_hazard_unit_if.slave   bus
);
    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_SRC*DATA_W-1:0] opnd_w;
    logic [NUM_SRC-1:0]        hit_w;
    logic [NUM_SRC-1:0]        haz_w;
    logic                      stall_w;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] sc_q, sc_d;
    logic [CNT_W-1:0] fe_q, fe_d;
    logic             wd_q, wd_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_sel #(
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W),
            .NUM_FWD    (NUM_FWD)
        ) u_sel (
            .fwd_en_i      (bus.fwd_en),
            .used_i        (bus.src_used[i]),
            .addr_i        (bus.src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .rf_data_i     (bus.rf_data[i*DATA_W +: DATA_W]),
            .st_wb_en_i    (bus.st_wb_en),
            .st_dest_i     (bus.st_dest),
            .st_data_i     (bus.st_data),
            .st_data_vld_i (bus.st_data_vld),
            .opnd_o        (opnd_w[i*DATA_W +: DATA_W]),
            .hit_o         (hit_w[i]),
            .hazard_o      (haz_w[i])
        );
    end

    assign stall_w          = bus.id_valid & (|haz_w);
    assign bus.opnd         = opnd_w;
    assign bus.fwd_hit      = hit_w;
    assign bus.stall        = stall_w;
    assign bus.stall_start  = start_q;
    assign bus.stall_cycles = sc_q;
    assign bus.fwd_events   = fe_q;
    assign bus.wd_err       = wd_q;

    // Next state: FSM, consecutive-stall run length, watchdog and counters
    always_comb begin
        state_d = stall_w ? STALL : RUN;
        start_d = (state_q == RUN) && stall_w;
        run_d   = '0;
        if (stall_w) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        end
        sc_d = sc_q;
        fe_d = fe_q;
        wd_d = wd_q | (run_d == RUN_MAX);
        if (stall_w && (sc_q != CNT_MAX)) begin
            sc_d = sc_q + CNT_W'(1);
        end
        if (bus.id_valid && !stall_w && (|hit_w) && (fe_q != CNT_MAX)) begin
            fe_d = fe_q + CNT_W'(1);
        end
        if (bus.clr_cnt) begin
            sc_d = '0;
            fe_d = '0;
            wd_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            run_q   <= '0;
            start_q <= 1'b0;
            sc_q    <= '0;
            fe_q    <= '0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            start_q <= start_d;
            sc_q    <= sc_d;
            fe_q    <= fe_d;
            wd_q    <= wd_d;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit.
// Directed cases with literal expectations, then random traffic vs a model.
module tb_fwd_hazard_unit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int NF = 3;
    localparam int MS = 16;
    localparam int CW = 16;

    logic clk;
    logic rst_n;
    logic cmp_en;
    int   total;
    int   bad;

    fwd_hazard_unit_if #(
        .DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .NUM_FWD(NF), .CNT_W(CW)
    ) bus ();

    fwd_hazard_unit #(
        .DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS), .NUM_FWD(NF),
        .MAX_STALL(MS), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    logic m_prev;
    logic m_start;
    logic m_wd;
    int   m_run;
    int   m_sc;
    int   m_fe;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Spec-level view: first matching stage from youngest, then decide.
    function automatic void model_comb(output logic [63:0] o,
                                       output logic [1:0] h,
                                       output logic st);
        logic any_haz;
        any_haz = 1'b0;
        o = '0;
        h = '0;
        for (int i = 0; i < NS; i++) begin
            int win;
            logic [AW-1:0] a;
            a = bus.src_addr[i*AW +: AW];
            win = -1;
            o[i*DW +: DW] = bus.rf_data[i*DW +: DW];
            if (bus.src_used[i] && a != 0) begin
                for (int s = 0; s < NF; s++) begin
                    if (win < 0 && bus.st_wb_en[s] &&
                        bus.st_dest[s*AW +: AW] == a) win = s;
                end
            end
            if (win >= 0) begin
                if (bus.fwd_en && bus.st_data_vld[win]) begin
                    o[i*DW +: DW] = bus.st_data[win*DW +: DW];
                    h[i] = 1'b1;
                end else begin
                    any_haz = 1'b1;
                end
            end
        end
        st = bus.id_valid & any_haz;
    endfunction

    // model update at each clock edge, cleared by async reset
    initial begin
        logic [63:0] o;
        logic [1:0]  h;
        logic        st;
        m_prev = 0; m_start = 0; m_wd = 0; m_run = 0; m_sc = 0; m_fe = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_prev = 0; m_start = 0; m_wd = 0;
                m_run = 0; m_sc = 0; m_fe = 0;
            end else begin
                model_comb(o, h, st);
                m_start = st && !m_prev;
                m_prev  = st;
                m_run   = st ? ((m_run < MS) ? m_run + 1 : MS) : 0;
                if (bus.clr_cnt) begin
                    m_sc = 0; m_fe = 0; m_wd = 0;
                end else begin
                    if (st && m_sc < 65535) m_sc++;
                    if (bus.id_valid && !st && (|h) && m_fe < 65535) m_fe++;
                    if (m_run == MS) m_wd = 1;
                end
            end
        end
    end

    // compare process on the inactive edge
    initial begin
        logic [63:0] o;
        logic [1:0]  h;
        logic        st;
        forever begin
            @(negedge clk);
            if (rst_n && cmp_en) begin
                model_comb(o, h, st);
                chk("m_opnd", 64'(bus.opnd), o);
                chk("m_hit", 64'(bus.fwd_hit), 64'(h));
                chk("m_stall", 64'(bus.stall), 64'(st));
                chk("m_start", 64'(bus.stall_start), 64'(m_start));
                chk("m_sc", 64'(bus.stall_cycles), 64'(m_sc));
                chk("m_fe", 64'(bus.fwd_events), 64'(m_fe));
                chk("m_wd", 64'(bus.wd_err), 64'(m_wd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid    = 1'b0;
        bus.fwd_en      = 1'b1;
        bus.clr_cnt     = 1'b0;
        bus.src_addr    = '0;
        bus.src_used    = '0;
        bus.rf_data     = {32'h2222_0002, 32'h1111_0001};
        bus.st_wb_en    = '0;
        bus.st_dest     = '0;
        bus.st_data     = '0;
        bus.st_data_vld = '1;
    endtask

    task automatic clr();
        idle();
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
    endtask

    // hazard via forwarding-disabled mode on r4
    task automatic hazard();
        idle();
        bus.id_valid          = 1'b1;
        bus.fwd_en            = 1'b0;
        bus.src_used          = 2'b01;
        bus.src_addr[4:0]     = 5'd4;
        bus.st_wb_en          = 3'b100;
        bus.st_dest[14:10]    = 5'd4;
        bus.st_data[95:64]    = 32'h0000_4444;
    endtask

    task automatic rand_in();
        bus.id_valid = ($urandom_range(0, 7) != 0);
        bus.fwd_en   = ($urandom_range(0, 7) != 0);
        bus.clr_cnt  = ($urandom_range(0, 63) == 0);
        bus.src_used = 2'($urandom_range(0, 3));
        bus.st_wb_en = 3'($urandom_range(0, 7));
        for (int i = 0; i < NS; i++) begin
            bus.src_addr[i*AW +: AW] = 5'($urandom_range(0, 3));
            bus.rf_data[i*DW +: DW]  = $urandom;
        end
        for (int s = 0; s < NF; s++) begin
            bus.st_dest[s*AW +: AW] = 5'($urandom_range(0, 3));
            bus.st_data[s*DW +: DW] = $urandom;
            bus.st_data_vld[s]      = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #3;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        chk("rst_start", 64'(bus.stall_start), 64'd0);
        chk("rst_sc", 64'(bus.stall_cycles), 64'd0);
        chk("rst_fe", 64'(bus.fwd_events), 64'd0);
        chk("rst_wd", 64'(bus.wd_err), 64'd0);
        tick();

        // youngest of two valid matches wins
        idle();
        bus.id_valid       = 1'b1;
        bus.src_used       = 2'b01;
        bus.src_addr[4:0]  = 5'd3;
        bus.st_wb_en       = 3'b011;
        bus.st_dest[4:0]   = 5'd3;
        bus.st_dest[9:5]   = 5'd3;
        bus.st_data[31:0]  = 32'hAAAA_0001;
        bus.st_data[63:32] = 32'h0000_5555;
        #2;
        chk("t1_opnd0", 64'(bus.opnd[31:0]), 64'hAAAA_0001);
        chk("t1_hit0", 64'(bus.fwd_hit[0]), 64'd1);
        chk("t1_stall", 64'(bus.stall), 64'd0);
        tick();
        chk("t1_fe", 64'(bus.fwd_events), 64'd1);
        clr();

        // load-use: young invalid beats old valid
        idle();
        bus.id_valid       = 1'b1;
        bus.src_used       = 2'b10;
        bus.src_addr[9:5]  = 5'd7;
        bus.st_wb_en       = 3'b101;
        bus.st_dest[4:0]   = 5'd7;
        bus.st_dest[14:10] = 5'd7;
        bus.st_data[31:0]  = 32'h0BAD_0007;
        bus.st_data[95:64] = 32'h0000_1234;
        bus.st_data_vld    = 3'b100;
        #2;
        chk("t2_stall", 64'(bus.stall), 64'd1);
        tick();
        chk("t2_start1", 64'(bus.stall_start), 64'd1);
        tick();
        chk("t2_start0", 64'(bus.stall_start), 64'd0);
        bus.st_data_vld = 3'b101;
        #2;
        chk("t2_unstall", 64'(bus.stall), 64'd0);
        chk("t2_opnd1", 64'(bus.opnd[63:32]), 64'h0BAD_0007);
        chk("t2_sc", 64'(bus.stall_cycles), 64'd2);
        tick();

        // r0 never forwards; unused source never stalls
        idle();
        bus.id_valid = 1'b1;
        bus.src_used = 2'b01;
        bus.st_wb_en = 3'b111;
        bus.st_data  = '1;
        bus.rf_data[31:0] = 32'hCAFE_0000;
        #2;
        chk("t3_opnd0", 64'(bus.opnd[31:0]), 64'hCAFE_0000);
        chk("t3_hit0", 64'(bus.fwd_hit[0]), 64'd0);
        chk("t3_stall", 64'(bus.stall), 64'd0);
        tick();
        bus.src_addr[9:5] = 5'd5;
        bus.st_dest       = {5'd5, 5'd5, 5'd5};
        bus.st_data_vld   = '0;
        #2;
        chk("t3_unused", 64'(bus.stall), 64'd0);
        tick();

        // forwarding disabled
        hazard();
        #2;
        chk("t4_stall", 64'(bus.stall), 64'd1);
        chk("t4_opnd0", 64'(bus.opnd[31:0]), 64'h1111_0001);
        bus.id_valid = 1'b0;
        #1;
        chk("t4_novalid", 64'(bus.stall), 64'd0);
        tick();

        // watchdog after 16 consecutive stall cycles
        clr();
        hazard();
        repeat (MS - 1) tick();
        chk("t5_wd15", 64'(bus.wd_err), 64'd0);
        tick();
        chk("t5_wd16", 64'(bus.wd_err), 64'd1);
        repeat (3) tick();
        chk("t5_sticky", 64'(bus.wd_err), 64'd1);
        clr();
        chk("t5_clr_wd", 64'(bus.wd_err), 64'd0);
        chk("t5_clr_sc", 64'(bus.stall_cycles), 64'd0);
        chk("t5_clr_fe", 64'(bus.fwd_events), 64'd0);

        // async reset in the middle of a stall
        hazard();
        repeat (MS) tick();
        idle();
        tick();
        hazard();
        tick();
        chk("t6_pre", 64'(bus.stall_start), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_start", 64'(bus.stall_start), 64'd0);
        chk("t6_sc", 64'(bus.stall_cycles), 64'd0);
        chk("t6_wd", 64'(bus.wd_err), 64'd0);
        chk("t6_fe", 64'(bus.fwd_events), 64'd0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("t6_run", 64'(bus.stall_start), 64'd1);

        // counter saturation
        repeat (65536 + 5) tick();
        chk("t6_sat", 64'(bus.stall_cycles), 64'hFFFF);
        clr();

        for (int n = 0; n < 3000; n++) begin
            rand_in();
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
